// File: rtl/monitor_contador_0_13.sv
// Receiving-end checker for a modulo-(MAX+1) counter bus: locks onto the count
// sequence, then flags illegal steps and tallies violations and legal wraps.
module monitor_contador_0_13 #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 13,
    parameter int SYNC_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic             locked,
    output logic             error,
    output logic             wrap,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);
    // Handshake: q_in is qualified by en alone; there is no backpressure, and
    // error/wrap are single-cycle pulses one clock after the sampling edge.
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);
    localparam logic [2:0]       SYNC_LEN_V = 3'(SYNC_LEN);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [2:0]         sync_cnt_q, sync_cnt_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   wrap_count_q, wrap_count_d;
    logic               in_range;
    logic [WIDTH-1:0]   expected;

    assign in_range = (q_in <= MAX_V);
    assign expected = (prev_q == MAX_V) ? '0 : prev_q + WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        sync_cnt_d   = sync_cnt_q;
        error_d      = 1'b0;
        wrap_d       = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (in_range) begin
                        prev_d     = q_in;
                        sync_cnt_d = '0;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (q_in == expected) begin
                        prev_d = q_in;
                        if (sync_cnt_q + 3'd1 == SYNC_LEN_V) begin
                            state_d    = LOCKED;
                            sync_cnt_d = '0;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 3'd1;
                        end
                    end else if (in_range) begin
                        prev_d     = q_in;
                        sync_cnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (q_in == expected) begin
                        prev_d = q_in;
                        if (prev_q == MAX_V) begin
                            wrap_d       = 1'b1;
                            wrap_count_d = wrap_count_q + CNT_W'(1);
                        end
                    end else begin
                        error_d = 1'b1;
                        // Saturate so a long fault burst never reads back as few errors.
                        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
                        if (in_range) begin
                            prev_d     = q_in;
                            sync_cnt_d = '0;
                            state_d    = SYNC;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            sync_cnt_q   <= '0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            wrap_q       <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            sync_cnt_q   <= sync_cnt_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            wrap_q       <= wrap_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign wrap       = wrap_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: doc/monitor_contador_0_13.md
Name: monitor_contador_0_13

Overview:
- Receiving-end checker for the 4-bit modulo counter output bus (0..MAX, wrap to 0).
- Samples the counter value on qualified cycles and locks onto the sequence.
- Flags every illegal step or out-of-range value, and counts errors and completed wraps.
- Sits beside any modulo counter in the lab designs as a self-check / on-board debug monitor.

Parameters:
- WIDTH, 4: width of monitored counter bus.
- MAX, 13: terminal value; legal range 0..MAX, successor of MAX is 0.
- SYNC_LEN, 2: consecutive correct steps required to declare lock (1..7).
- CNT_W, 8: width of error and wrap counters.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- en  in  1  sample qualifier; q_in is evaluated only when en=1.
- q_in  in  WIDTH  counter value under observation.
- locked  out  1  high while FSM is in LOCKED.
- error  out  1  one-cycle pulse on a detected violation.
- wrap  out  1  one-cycle pulse on a legal MAX->0 step while LOCKED.
- err_count  out  CNT_W  violations seen; saturates at all-ones.
- wrap_count  out  CNT_W  legal wraps seen while LOCKED; rolls over modulo 2^CNT_W.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high: rst=1 forces the FSM to HUNT and all outputs and internal registers to 0 immediately, independent of clk.
- All outputs are registered. error and wrap assert in the cycle after the clk edge that sampled the triggering q_in; latency is 1 cycle.
- en=0: no state change; prev, sync_cnt and the counters hold; error=0, wrap=0.
- Definitions:
  - in_range = (q_in <= MAX).
  - expected = (prev == MAX) ? 0 : prev + 1, computed in WIDTH bits.
- FSM states, evaluated per sample (en=1):
  - HUNT:
    - in_range: prev <= q_in, sync_cnt <= 0, go to SYNC.
    - Otherwise stay in HUNT. No error is reported in HUNT.
  - SYNC:
    - q_in == expected: prev <= q_in, sync_cnt++. If sync_cnt+1 == SYNC_LEN, go to LOCKED with sync_cnt <= 0.
    - Otherwise, if in_range: prev <= q_in, sync_cnt <= 0, stay in SYNC.
    - Otherwise go to HUNT.
    - No error is reported in SYNC.
  - LOCKED:
    - q_in == expected: prev <= q_in. If prev == MAX (the step was MAX->0), pulse wrap and increment wrap_count.
    - Otherwise: pulse error and increment err_count (saturating). If in_range, prev <= q_in, sync_cnt <= 0, go to SYNC; else go to HUNT.
- locked = (state == LOCKED), registered.
- Boundary cases:
  - A repeated value (q_in == prev) while LOCKED is an error. A stalled counter must be gated with en=0.
  - The error and wrap pulses are mutually exclusive.
  - A single corrupt sample costs exactly one error. Re-lock takes SYNC_LEN further correct steps.
  - err_count holds at 2^CNT_W-1. wrap_count wraps to 0.
  - Values MAX+1..2^WIDTH-1 are never legal.
  - rst asserted mid-sequence drops lock immediately. After rst deasserts, lock needs 1 + SYNC_LEN samples.
- Outputs after reset deassertion with no en: locked=0, error=0, wrap=0, both counts 0.

Test Plan:
- Reset, then en=1 with q_in = 0,1,2 -> locked=0 after 0 and after 1; locked=1 the cycle after sampling 2; err_count=0.
- Locked, feed 12,13,0,1 -> wrap pulses once, 1 cycle after sampling 0; wrap_count=1; no error.
- Locked at 5, inject 9 then 10,11 -> error pulse once, err_count=1, locked=0; relocks the cycle after sampling 11.
- Locked, inject 14 -> error, FSM to HUNT; then 3,4,5 -> locked=1 after 5; err_count=1.
- Locked at 7, en=0 for 4 cycles with q_in=7, then en=1 with 8 -> no error, still locked; same hold with en=1 -> error.
- CNT_W=2, force 5 violations -> err_count saturates at 3. Assert rst mid-lock -> locked/error/counts read 0 immediately, without a clock edge.
